// File: rtl/input_event_queue_pkg.sv
// Purpose: shared source codes, widths and arbitration helper for the input event queue.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
// Config macro: INPUT_EVENT_TIMESTAMP_EN widens each event word from 8 to 24 bits.
package input_event_queue_pkg;

  localparam int EV_CODE_W  = 3;
  localparam int EV_BASE_W  = 8;
  localparam int EV_TS_W    = 16;
  localparam int EV_NUM_SRC = 8;

`ifdef INPUT_EVENT_TIMESTAMP_EN
  localparam int EV_W = EV_BASE_W + EV_TS_W;
`else
  localparam int EV_W = EV_BASE_W;
`endif

  // Source codes double as arbitration priority: lowest code wins.
  localparam logic [EV_CODE_W-1:0] EV_CENTER    = 3'd0;
  localparam logic [EV_CODE_W-1:0] EV_EAST      = 3'd1;
  localparam logic [EV_CODE_W-1:0] EV_NORTH     = 3'd2;
  localparam logic [EV_CODE_W-1:0] EV_SOUTH     = 3'd3;
  localparam logic [EV_CODE_W-1:0] EV_WEST      = 3'd4;
  localparam logic [EV_CODE_W-1:0] EV_ROT_PUSH  = 3'd5;
  localparam logic [EV_CODE_W-1:0] EV_ROT_LEFT  = 3'd6;
  localparam logic [EV_CODE_W-1:0] EV_ROT_RIGHT = 3'd7;

  // Index of the lowest set bit; returns 0 when nothing is set (caller qualifies).
  function automatic logic [EV_CODE_W-1:0] lowest_src(input logic [EV_NUM_SRC-1:0] p);
    logic [EV_CODE_W-1:0] code;
    code = '0;
    for (int i = EV_NUM_SRC - 1; i >= 0; i--) begin
      if (p[i]) code = i[EV_CODE_W-1:0];
    end
    return code;
  endfunction

endpackage

// File: rtl/input_event_queue_if.sv
// Purpose: consumer-side bundle of the input event queue (head, pop, occupancy, overflow).
// Latency: n/a (wires only).
// Backpressure: consumer pops with ev_ready while ev_valid is high.
// Ports: ev_valid/ev_data/ev_count/overflow driven by the queue (master);
//        ev_ready/clear_overflow driven by the consumer (slave).
interface input_event_queue_if #(
  parameter int W     = 8,
  parameter int CNT_W = 4
);
  logic             ev_valid;
  logic             ev_ready;
  logic [W-1:0]     ev_data;
  logic [CNT_W-1:0] ev_count;
  logic             overflow;
  logic             clear_overflow;

  modport master (
    output ev_valid, ev_data, ev_count, overflow,
    input  ev_ready, clear_overflow
  );

  modport slave (
    input  ev_valid, ev_data, ev_count, overflow,
    output ev_ready, clear_overflow
  );
endinterface

// File: rtl/input_event_queue_sync_fifo.sv
// Purpose: single-clock FIFO, power-of-two DEPTH, head word readable combinationally.
// Latency: push visible at rd_dat_o one cycle later; pop takes effect at the edge.
// Backpressure: push dropped when full unless a pop happens in the same cycle.
// Ports: clk, rst (sync, active high); push_i/push_dat_i; pop_i; rd_dat_o; full_o/empty_o/count_o.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rd_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o   = (count_q == CW'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign rd_dat_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot in the same edge, so a full FIFO can still accept.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are AW bits wide, so increment wraps modulo DEPTH.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale words are hidden behind empty_o.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/input_event_queue.sv
// Purpose: latch button/rotary pulses into per-source pending bits, arbitrate lowest code into a FIFO.
// Latency: pulse in cycle N -> ev_valid in cycle N+2 when idle and empty.
// Backpressure: full FIFO holds pending bits; a repeat pulse on a held source is dropped and sets overflow.
// Ports: clk, rst (sync, active high); compass_buttons[4:0], rotary_push, rotary_event, rotary_left;
//        ev_if (master): ev_valid, ev_ready, ev_data, ev_count, overflow, clear_overflow.
// Config macro: INPUT_EVENT_TIMESTAMP_EN adds a 16-bit free-running stamp in ev_data[23:8].
module input_event_queue
  import input_event_queue_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int CPU_CLOCK_FREQ = 50_000_000  // timestamp tick rate, documentation only
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           compass_buttons,
  input  logic                 rotary_push,
  input  logic                 rotary_event,
  input  logic                 rotary_left,
  input_event_queue_if.master  ev_if
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || CPU_CLOCK_FREQ < 1) begin : g_bad_param
    $error("input_event_queue: DEPTH must be a power of two in 2..64");
  end

  logic [EV_NUM_SRC-1:0] src_pulse, pending_q, pending_d, deq_mask;
  logic                  overflow_q, overflow_d;
  logic [EV_CODE_W-1:0]  enq_code;
  logic [EV_W-1:0]       enq_dat;
  logic                  enq, pop, drop;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;

  always_comb begin
    src_pulse               = '0;
    src_pulse[EV_CENTER]    = compass_buttons[0];
    src_pulse[EV_EAST]      = compass_buttons[1];
    src_pulse[EV_NORTH]     = compass_buttons[2];
    src_pulse[EV_SOUTH]     = compass_buttons[3];
    src_pulse[EV_WEST]      = compass_buttons[4];
    src_pulse[EV_ROT_PUSH]  = rotary_push;
    src_pulse[EV_ROT_LEFT]  = rotary_event && rotary_left;
    src_pulse[EV_ROT_RIGHT] = rotary_event && !rotary_left;
  end

  assign pop = !fifo_empty && ev_if.ev_ready;

`ifdef INPUT_EVENT_TIMESTAMP_EN
  logic [EV_TS_W-1:0] ts_q, ts_d;
  assign ts_d = ts_q + 1'b1;  // wraps at 0xFFFF
  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_d;
  end
  assign enq_dat = {ts_q, {(EV_BASE_W - EV_CODE_W){1'b0}}, enq_code};
`else
  assign enq_dat = {{(EV_BASE_W - EV_CODE_W){1'b0}}, enq_code};
`endif

  // Arbitration only looks at registered pending bits, which gives the
  // two-cycle pulse-to-valid latency and keeps inputs off the FIFO path.
  always_comb begin
    enq_code   = lowest_src(pending_q);
    enq        = (|pending_q) && (!fifo_full || pop);
    deq_mask   = enq ? (EV_NUM_SRC'(1) << enq_code) : '0;
    // A pulse on a bit being dequeued this edge simply re-arms it.
    pending_d  = (pending_q & ~deq_mask) | src_pulse;
    drop       = |(src_pulse & pending_q & ~deq_mask);
    // Set wins over clear.
    overflow_d = drop || (overflow_q && !ev_if.clear_overflow);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (EV_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (enq),
    .push_dat_i (enq_dat),
    .pop_i      (pop),
    .rd_dat_o   (ev_if.ev_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign ev_if.ev_valid = !fifo_empty;
  assign ev_if.ev_count = fifo_count;
  assign ev_if.overflow = overflow_q;

endmodule
